// File: rtl/note_track_if.sv
// Spectral-frame input, note-lookup handshake and note report signals of note_track_ctrl.
interface note_track_if #(
  parameter int MAG_WIDTH = 32
);
  logic [MAG_WIDTH-1:0] mag_in;
  logic                 mag_valid_in;
  logic                 mag_last_in;
  logic [12:0]          lookup_bin_out;
  logic                 lookup_ready_out;
  logic [5:0]           lookup_note_in;
  logic [5:0]           note_out;
  logic                 note_valid_out;
  logic                 busy_out;
  logic                 frame_drop_out;

  modport master (
    output mag_in, mag_valid_in, mag_last_in, lookup_note_in,
    input  lookup_bin_out, lookup_ready_out, note_out, note_valid_out, busy_out, frame_drop_out
  );

  modport slave (
    input  mag_in, mag_valid_in, mag_last_in, lookup_note_in,
    output lookup_bin_out, lookup_ready_out, note_out, note_valid_out, busy_out, frame_drop_out
  );
endinterface

// File: rtl/note_track_ctrl.sv
// Per-frame spectral peak picker driving a bin-to-note lookup, with hysteresis on the
// reported note and discarding of frames that start while a lookup is in flight.
module note_track_ctrl #(
  parameter int NUM_BINS    = 4096,
  parameter int MIN_BIN     = 120,
  parameter int MAX_BIN     = 440,
  parameter int MAG_WIDTH   = 32,
  parameter int MAG_THRESH  = 1000,
  parameter int LOOKUP_WAIT = 24,
  parameter int HOLD_FRAMES = 3
) (
  input logic         clk_in,
  input logic         rst_in,
  note_track_if.slave bus
);
  localparam int WAIT_W = (LOOKUP_WAIT > 1) ? $clog2(LOOKUP_WAIT) : 1;
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [12:0]          LAST_BIN = 13'(NUM_BINS - 1);
  localparam logic [12:0]          LO_BIN   = 13'(MIN_BIN);
  localparam logic [12:0]          HI_BIN   = 13'(MAX_BIN);
  localparam logic [MAG_WIDTH-1:0] THRESH   = MAG_WIDTH'(MAG_THRESH);

  typedef enum logic [1:0] {SCAN, REQ, WAIT, DECIDE} state_t;

  state_t               state;
  logic [12:0]          bin_cnt;
  logic                 bin_ovf;
  logic [MAG_WIDTH-1:0] run_max;
  logic [12:0]          run_bin;
  logic [MAG_WIDTH-1:0] peak_mag;
  logic                 in_frame;
  logic                 dropping;
  logic [5:0]           prev_cand;
  logic [HOLD_W-1:0]    stable_cnt;
  logic [WAIT_W-1:0]    wait_cnt;

  function automatic logic [HOLD_W-1:0] sat_hold(input logic [HOLD_W-1:0] c);
    return (c >= HOLD_W'(HOLD_FRAMES)) ? HOLD_W'(HOLD_FRAMES) : c + HOLD_W'(1);
  endfunction

  function automatic logic [12:0] sat_bin(input logic [12:0] c);
    return (c == LAST_BIN) ? c : c + 13'd1;
  endfunction

  logic                 drop_start;
  logic                 drop_now;
  logic                 bin_take;
  logic                 eligible;
  logic [MAG_WIDTH-1:0] cur_max;
  logic [12:0]          cur_bin;
  logic [5:0]           cand;
  logic [HOLD_W-1:0]    next_stable;

  // A frame is dropped when its first valid bin shows up while a lookup is in flight.
  always_comb begin
    drop_start  = bus.mag_valid_in && !in_frame && (state != SCAN);
    drop_now    = dropping || drop_start;
    bin_take    = bus.mag_valid_in && (state == SCAN) && !drop_now;
    eligible    = !bin_ovf && (bin_cnt >= LO_BIN) && (bin_cnt <= HI_BIN);
    cur_max     = run_max;
    cur_bin     = run_bin;
    if (bin_take && eligible && (bus.mag_in > run_max)) begin
      cur_max = bus.mag_in;
      cur_bin = bin_cnt;
    end
    cand        = ((peak_mag < THRESH) || !bus.lookup_note_in[5]) ? 6'd0 : bus.lookup_note_in;
    next_stable = (cand == prev_cand) ? sat_hold(stable_cnt) : HOLD_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= SCAN;
      bin_cnt              <= '0;
      bin_ovf              <= 1'b0;
      run_max              <= '0;
      run_bin              <= '0;
      peak_mag             <= '0;
      in_frame             <= 1'b0;
      dropping             <= 1'b0;
      prev_cand            <= '0;
      stable_cnt           <= '0;
      wait_cnt             <= '0;
      bus.lookup_bin_out   <= '0;
      bus.lookup_ready_out <= 1'b0;
      bus.note_out         <= '0;
      bus.note_valid_out   <= 1'b0;
      bus.busy_out         <= 1'b0;
      bus.frame_drop_out   <= 1'b0;
    end else begin
      bus.lookup_ready_out <= 1'b0;
      bus.note_valid_out   <= 1'b0;
      bus.frame_drop_out   <= 1'b0;

      if (bus.mag_valid_in) begin
        if (bus.mag_last_in) begin
          in_frame <= 1'b0;
          dropping <= 1'b0;
          if (drop_now) bus.frame_drop_out <= 1'b1;
        end else begin
          in_frame <= 1'b1;
          if (drop_start) dropping <= 1'b1;
        end
      end

      if (bin_take) begin
        if (bus.mag_last_in) begin
          bin_cnt <= '0;
          bin_ovf <= 1'b0;
          run_max <= '0;
          run_bin <= '0;
        end else begin
          run_max <= cur_max;
          run_bin <= cur_bin;
          bin_cnt <= sat_bin(bin_cnt);
          if (bin_cnt == LAST_BIN) bin_ovf <= 1'b1;
        end
      end

      case (state)
        SCAN: begin
          if (bin_take && bus.mag_last_in) begin
            bus.lookup_bin_out   <= cur_bin;
            peak_mag             <= cur_max;
            bus.lookup_ready_out <= 1'b1;
            bus.busy_out         <= 1'b1;
            state                <= REQ;
          end
        end
        REQ: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == WAIT_W'(LOOKUP_WAIT - 1)) state <= DECIDE;
          else wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        DECIDE: begin
          prev_cand  <= cand;
          stable_cnt <= next_stable;
          if ((next_stable == HOLD_W'(HOLD_FRAMES)) && (cand != bus.note_out)) begin
            bus.note_out       <= cand;
            bus.note_valid_out <= 1'b1;
          end
          bus.busy_out <= 1'b0;
          state        <= SCAN;
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_note_track_ctrl.sv
// Directed and randomized frames for note_track_ctrl, checked against a frame-level reference model.
module tb_note_track_ctrl;
  localparam int NUM_BINS    = 441;
  localparam int MIN_BIN     = 120;
  localparam int MAX_BIN     = 440;
  localparam int MAG_WIDTH   = 32;
  localparam int MAG_THRESH  = 1000;
  localparam int LOOKUP_WAIT = 24;
  localparam int HOLD_FRAMES = 3;
  localparam int LAT         = LOOKUP_WAIT + 3;
  localparam logic [5:0] NOTE_A = 6'b101001;
  localparam logic [5:0] NOTE_B = 6'b100101;
  localparam logic [5:0] MISS   = 6'b000011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_track_if #(.MAG_WIDTH(MAG_WIDTH)) bus ();

  note_track_ctrl #(
    .NUM_BINS(NUM_BINS), .MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN), .MAG_WIDTH(MAG_WIDTH),
    .MAG_THRESH(MAG_THRESH), .LOOKUP_WAIT(LOOKUP_WAIT), .HOLD_FRAMES(HOLD_FRAMES)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;
  int mags [0:599];
  bit gaps = 1'b0;

  int ready_cnt, drop_cnt, drop_lat, nv_cnt, nv_lat, unstable;
  logic [12:0] bin_cap;

  int model_note = 0;
  int hist [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    ready_cnt = 0; drop_cnt = 0; drop_lat = 0; nv_cnt = 0; nv_lat = 0; unstable = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (bus.lookup_ready_out === 1'b1) begin
      ready_cnt++;
      bin_cap = bus.lookup_bin_out;
    end else if (bus.busy_out === 1'b1 && bus.lookup_bin_out !== bin_cap) begin
      unstable++;
    end
    if (bus.note_valid_out === 1'b1) begin nv_cnt++; nv_lat = cyc - last_cyc; end
    if (bus.frame_drop_out === 1'b1) begin drop_cnt++; drop_lat = cyc - last_cyc; end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.mag_valid_in = 1'b0;
      bus.mag_last_in  = 1'($urandom_range(0, 1));
      bus.mag_in       = $urandom;
      tick();
    end
    bus.mag_last_in = 1'b0;
  endtask

  task automatic fill(input int len, input int maxv);
    for (int i = 0; i < 600; i++) mags[i] = (i < len) ? int'($urandom_range(0, maxv)) : 0;
  endtask

  task automatic drive_frame(input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.mag_valid_in = 1'b0;
        bus.mag_last_in  = 1'($urandom_range(0, 1));
        bus.mag_in       = $urandom;
        tick();
      end
      bus.mag_valid_in = 1'b1;
      bus.mag_in       = 32'(mags[i]);
      bus.mag_last_in  = with_last && (i == len - 1);
      if (bus.mag_last_in) last_cyc = cyc;
      tick();
    end
    bus.mag_valid_in = 1'b0;
    bus.mag_last_in  = 1'b0;
  endtask

  // Frame-level model: peak over eligible bins, then "last HOLD_FRAMES decisions agree" hysteresis.
  task automatic model_frame(input int len, input logic [5:0] lk, output int pbin, output bit rep);
    int pmag, cand;
    bit same;
    pbin = 0; pmag = 0;
    for (int i = 0; i < len; i++)
      if (i >= MIN_BIN && i <= MAX_BIN && i <= NUM_BINS - 1 && mags[i] > pmag) begin
        pbin = i; pmag = mags[i];
      end
    cand = (pmag < MAG_THRESH || !lk[5]) ? 0 : int'(lk);
    hist.push_back(cand);
    if (hist.size() > HOLD_FRAMES) void'(hist.pop_front());
    same = (hist.size() == HOLD_FRAMES);
    foreach (hist[j]) if (hist[j] != cand) same = 1'b0;
    rep = same && (cand != model_note);
    if (rep) model_note = cand;
  endtask

  task automatic run_frame(input int len, input logic [5:0] lk, input string tag);
    int pbin;
    bit rep;
    clear_obs();
    bus.lookup_note_in = lk;
    model_frame(len, lk, pbin, rep);
    drive_frame(len, 1'b1);
    idle(LAT + 3);
    check({tag, "_ready"}, ready_cnt, 1);
    check({tag, "_bin"}, 32'(bin_cap), pbin);
    check({tag, "_bin_stable"}, unstable, 0);
    check({tag, "_nv_pulses"}, nv_cnt, rep ? 1 : 0);
    if (rep) check({tag, "_nv_latency"}, nv_lat, LAT);
    check({tag, "_note"}, 32'(bus.note_out), model_note);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_busy_idle"}, 32'(bus.busy_out), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_note"}, 32'(bus.note_out), 0);
    check({tag, "_note_valid"}, 32'(bus.note_valid_out), 0);
    check({tag, "_ready"}, 32'(bus.lookup_ready_out), 0);
    check({tag, "_busy"}, 32'(bus.busy_out), 0);
    check({tag, "_drop"}, 32'(bus.frame_drop_out), 0);
    check({tag, "_bin"}, 32'(bus.lookup_bin_out), 0);
  endtask

  initial begin
    int pbin, len;
    bit rep;
    logic [5:0] lk;
    bus.mag_in = '0; bus.mag_valid_in = 1'b0; bus.mag_last_in = 1'b0; bus.lookup_note_in = '0;
    bin_cap = '0;
    rst = 1'b1;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    idle(3);

    // Three identical frames with a strong peak at bin 200.
    for (int f = 0; f < 3; f++) begin
      fill(441, 3999); mags[200] = 5000;
      run_frame(441, NOTE_A, "hold");
    end
    check("hold_note_direct", 32'(bus.note_out), 32'(NOTE_A));

    // Tie between 150 and 300; larger peak at out-of-range bin 100.
    gaps = 1'b1;
    fill(441, 3999); mags[150] = 5000; mags[300] = 5000; mags[100] = 9000;
    run_frame(441, NOTE_A, "tie");
    check("tie_bin_direct", 32'(bin_cap), 150);

    // Weak peaks decay to silence after three frames, then stay silent.
    for (int f = 0; f < 4; f++) begin
      fill(441, 499); mags[250] = 500;
      run_frame(441, 6'b100111, "weak");
    end
    check("weak_note_direct", 32'(bus.note_out), 0);

    // Over-long frame: bins past NUM_BINS-1 are never eligible.
    fill(470, 3999); mags[300] = 5000; mags[450] = 9000;
    run_frame(470, NOTE_B, "ovf");

    // Alternating notes never settle.
    for (int f = 0; f < 4; f++) begin
      fill(441, 3999); mags[130 + 40 * f] = 6000;
      run_frame(441, (f % 2 == 0) ? NOTE_A : NOTE_B, "alt");
    end
    check("alt_note_direct", 32'(bus.note_out), 0);

    // Frame starting while busy is dropped, including bins after busy ends.
    gaps = 1'b0;
    clear_obs();
    bus.lookup_note_in = NOTE_A;
    fill(441, 3999); mags[200] = 5000;
    model_frame(441, NOTE_A, pbin, rep);
    drive_frame(441, 1'b1);
    fill(60, 9000);
    drive_frame(60, 1'b1);
    idle(LAT + 3);
    check("drop_ready", ready_cnt, 1);
    check("drop_bin", 32'(bin_cap), pbin);
    check("drop_pulses", drop_cnt, 1);
    check("drop_latency", drop_lat, 1);
    check("drop_nv_pulses", nv_cnt, rep ? 1 : 0);
    check("drop_note", 32'(bus.note_out), model_note);
    fill(441, 3999); mags[200] = 5000;
    run_frame(441, NOTE_A, "after_drop");

    // Randomized frames with repeats, misses and weak peaks.
    lk = NOTE_A;
    for (int f = 0; f < 10; f++) begin
      gaps = 1'($urandom_range(0, 1));
      len = int'($urandom_range(200, 460));
      fill(len, ($urandom_range(0, 3) == 0) ? 900 : 20000);
      if ($urandom_range(0, 1) == 0)
        case ($urandom_range(0, 2))
          0: lk = NOTE_A;
          1: lk = NOTE_B;
          default: lk = MISS;
        endcase
      run_frame(len, lk, "rand");
    end

    // Reset while waiting on the lookup abandons the frame.
    gaps = 1'b0;
    clear_obs();
    fill(441, 3999); mags[200] = 5000;
    bus.lookup_note_in = NOTE_B;
    drive_frame(441, 1'b1);
    idle(10);
    rst = 1'b1;
    tick();
    check_all_zero("rst_wait");
    rst = 1'b0;
    hist.delete();
    model_note = 0;
    clear_obs();
    idle(LAT + 10);
    check("rst_wait_no_ready", ready_cnt, 0);
    check("rst_wait_no_nv", nv_cnt, 0);
    check("rst_wait_no_drop", drop_cnt, 0);

    // Reset mid-frame, then frames process normally.
    fill(441, 3999);
    drive_frame(100, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_obs();
    idle(5);
    check("rst_frame_no_drop", drop_cnt, 0);
    for (int f = 0; f < 3; f++) begin
      fill(441, 3999); mags[333] = 7000;
      run_frame(441, NOTE_B, "post_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_track_ctrl.md
NOTE_TRACK_CTRL -- requirements
Module: note_track_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_BINS, 4096, FFT bins per frame
- MIN_BIN, 120, lowest bin eligible as a peak
- MAX_BIN, 440, highest bin eligible as a peak
- MAG_WIDTH, 32, magnitude width in bits
- MAG_THRESH, 1000, minimum peak magnitude treated as a note
- LOOKUP_WAIT, 24, cycles allowed for the bin-to-note lookup
- HOLD_FRAMES, 3, consecutive equal frames required before a report
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_in, in, 1, the single clock
- rst_in, in, 1, synchronous active-high reset
- mag_in, in, MAG_WIDTH, unsigned bin magnitude
- mag_valid_in, in, 1, mag_in valid this cycle
- mag_last_in, in, 1, final bin of the frame; qualified by mag_valid_in
- lookup_bin_out, out, 13, bin index presented to the note lookup
- lookup_ready_out, out, 1, one-cycle lookup start pulse
- lookup_note_in, in, 6, lookup result; bit5 = hit, bits[4:0] = note
- note_out, out, 6, reported note; 0 = silence
- note_valid_out, out, 1, one-cycle pulse when note_out changes
- busy_out, out, 1, high in every state except SCAN
- frame_drop_out, out, 1, one-cycle pulse per discarded frame

Function
REQ-003 FSM states: SCAN, REQ, WAIT, DECIDE.
REQ-004 SCAN:
- each valid bin increments the 13-bit bin counter (starts at 0)
- counter returns to 0 after mag_last_in
- only bins MIN_BIN..MAX_BIN inclusive are compared
- strict greater-than compare: on a tie the lower bin wins
REQ-005 SCAN exit: a valid mag_last_in loads lookup_bin_out = peak bin, latches peak magnitude, clears the running max, and moves to REQ next cycle. If no bin was in range, the peak bin is 0 and the peak magnitude is 0.
REQ-006 REQ: assert lookup_ready_out for exactly one cycle, then go to WAIT.
REQ-007 WAIT: count LOOKUP_WAIT cycles, then go to DECIDE. lookup_bin_out SHALL stay stable from REQ entry through DECIDE.
REQ-008 DECIDE: sample lookup_note_in in a single cycle.
- candidate = 0 if peak magnitude < MAG_THRESH or lookup_note_in[5] = 0
- otherwise candidate = lookup_note_in
- return to SCAN next cycle
REQ-009 Hysteresis:
- candidate equals previous candidate: stable count increments, saturating at HOLD_FRAMES
- candidate differs: previous candidate := candidate, stable count := 1
REQ-010 Report: when stable count reaches HOLD_FRAMES in DECIDE and the candidate differs from note_out, update note_out and pulse note_valid_out in the same cycle. No pulse when the note is unchanged.
REQ-011 Frame drops:
- valid bins arriving while busy_out = 1 are ignored
- a frame whose first valid bin arrives while busy is discarded entirely, including any bins after the return to SCAN
- frame_drop_out pulses at that frame's mag_last_in
- the next frame is scanned normally
REQ-012 mag_last_in with mag_valid_in = 0 SHALL be ignored.
REQ-013 Bins beyond NUM_BINS-1 without mag_last_in: the counter SHALL saturate at NUM_BINS-1 and those bins are not eligible.
REQ-014 Latency: note_valid_out occurs exactly LOOKUP_WAIT+3 cycles after the mag_last_in cycle.

Reset
REQ-015 rst_in sampled high at a clock edge SHALL, on that edge:
- force SCAN
- zero the bin counter, running max, peak, candidate, and stable count
- force note_out = 0, lookup_bin_out = 0
- force lookup_ready_out, note_valid_out, busy_out, frame_drop_out = 0
REQ-016 Reset asserted mid-frame or mid-lookup SHALL abandon that frame with no report and no drop pulse.

Verification
REQ-017 Three identical frames, peak magnitude 5000 at bin 200, lookup returns 6'b101001 -> note_out = 6'b101001 and note_valid_out pulses once, 27 cycles after the third mag_last_in.
REQ-018 Magnitude 5000 at bins 150 and 300 (tie) -> lookup_bin_out = 150. Peak of 9000 at bin 100 (out of range) -> not selected.
REQ-019 After the note is reported, three frames with peak magnitude 500 -> note_out = 0 with one pulse. A fourth such frame -> no pulse.
REQ-020 Frame starting while busy -> frame_drop_out pulses at its last bin, no lookup pulse is issued, and the following frame is processed normally.
REQ-021 Alternating notes A,B,A,B -> no report. rst_in during WAIT -> all outputs 0, and lookup_ready_out stays low until the next full frame.
